mem_bus_arbiter: RTL

//   Shares one external 32-bit memory bus between instruction fetch (IF, read-only) and the MEM stage (LB/LW/SB/SW).

---
 rtl/mem_bus_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one 32-bit req/ack memory bus between instruction fetch and the MEM stage (MEM has priority).
// Latency is request seen -> ready two cycles minimum. Requesters are stalled while they wait, and a
// transaction aborts with bus_err_o once TIMEOUT busy cycles pass with no ack.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o,
  output logic        stallreq_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BUSY_IF  = 2'd1;
  localparam logic [1:0] S_BUSY_MEM = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;
  logic          w_finish;

  // An ack arriving in the last allowed cycle takes precedence over the abort.
  assign w_timeout = (TIMEOUT != 0) && !bus_ack_i && (r_cnt == TMO_LAST);
  assign w_finish  = bus_ack_i || w_timeout;

  assign stallreq_o = (mem_ce_i & ~mem_ready_o) | (if_ce_i & ~if_ready_o);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      bus_err_o   <= 1'b0;
      if_data_o   <= '0;
      if_ready_o  <= 1'b0;
      mem_data_o  <= '0;
      mem_ready_o <= 1'b0;
    end else begin
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
      bus_err_o   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_ce_i) begin
            r_state     <= S_BUSY_MEM;
            r_cnt       <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_sel_o   <= mem_sel_i;
            bus_wdata_o <= mem_data_i;
          end else if (if_ce_i) begin
            r_state     <= S_BUSY_IF;
            r_cnt       <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i;
            bus_sel_o   <= 4'hF;
            bus_wdata_o <= '0;
          end
        end
        S_BUSY_IF, S_BUSY_MEM: begin
          if (w_finish) begin
            r_state   <= S_DONE;
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_err_o <= !bus_ack_i;
            if (r_state == S_BUSY_MEM) begin
              mem_data_o  <= bus_ack_i ? bus_rdata_i : 32'd0;
              mem_ready_o <= 1'b1;
            end else begin
              if_data_o  <= bus_ack_i ? bus_rdata_i : 32'd0;
              if_ready_o <= 1'b1;
            end
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
